// File: rtl/uart_pkg.sv
// Shared UART constants and types used by the receive-side blocks.
package uart_pkg;

  localparam int UART_DW            = 8;
  localparam int UART_RXBUF_DEPTH   = 16;
  localparam int UART_BAUD_9600_DIV = 325;

  typedef logic [UART_DW-1:0] uartByte_t;

endpackage

// File: rtl/uart_rx_buffer_if.sv
// Receiver-to-buffer and buffer-to-consumer signals plus status, bundled.
// master: the side that drives RxDone/RxData/OutReady/OvfClr.
// slave:  the buffer itself.
interface uart_rx_buffer_if #(
  parameter int AW = 4
);
  import uart_pkg::*;

  logic      RxDone;
  uartByte_t RxData;
  uartByte_t OutData;
  logic      OutValid;
  logic      OutReady;
  logic [AW:0] Count;
  logic      AlmostFull;
  logic      Overflow;
  logic      OvfClr;

  modport master (
    output RxDone, RxData, OutReady, OvfClr,
    input  OutData, OutValid, Count, AlmostFull, Overflow
  );

  modport slave (
    input  RxDone, RxData, OutReady, OvfClr,
    output OutData, OutValid, Count, AlmostFull, Overflow
  );
endinterface

// File: rtl/uart_fifo_ram.sv
// Byte storage for the receive FIFO: one synchronous write port and one
// asynchronous read port so the head byte falls through without latency.
module uart_fifo_ram
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_RXBUF_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          Clk,
  input  logic          wrEn,
  input  logic [AW-1:0] wrAddr,
  input  uartByte_t     wrData,
  input  logic [AW-1:0] rdAddr,
  output uartByte_t     rdData
);

  uartByte_t mem [DEPTH];

  // Write port; contents are intentionally never reset.
  always_ff @(posedge Clk) begin
    if (wrEn) mem[wrAddr] <= wrData;
  end

  assign rdData = mem[rdAddr];

endmodule

// File: rtl/uart_rx_buffer.sv
// FWFT byte FIFO behind the UART receiver: edge-detects RxDone, stores each
// completed byte, and reports occupancy, almost-full and sticky overflow.
module uart_rx_buffer
  import uart_pkg::*;
#(
  parameter int DEPTH       = UART_RXBUF_DEPTH,
  parameter int AW          = $clog2(DEPTH),
  parameter int AFULL_LEVEL = 12
) (
  input logic             Clk,
  input logic             Rst,
  uart_rx_buffer_if.slave rxIf
);

  logic          rxDoneD;
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic [AW:0]   count;
  logic          overflow;
  logic          push;
  logic          pop;
  logic          full;
  logic          outValid;
  logic          wrEn;
  logic          drop;
  uartByte_t     rdData;

  assign outValid = (count != '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign push     = rxIf.RxDone & ~rxDoneD;
  assign pop      = outValid & rxIf.OutReady;
  // A push into a full FIFO still lands if the head leaves in the same cycle:
  // the slot being written is the one being read out.
  assign wrEn     = ~Rst & push & (~full | pop);
  assign drop     = push & full & ~pop;

  // Edge-detector history keeps tracking RxDone through reset, so a RxDone
  // already high at reset release is seen as old and never pushes.
  always_ff @(posedge Clk) begin
    rxDoneD <= rxIf.RxDone;
  end

  // Pointers, occupancy and sticky overflow.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wrEn) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      case ({wrEn, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop)             overflow <= 1'b1;
      else if (rxIf.OvfClr) overflow <= 1'b0;
    end
  end

  uart_fifo_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) uRam (
    .Clk    (Clk),
    .wrEn   (wrEn),
    .wrAddr (wrPtr),
    .wrData (rxIf.RxData),
    .rdAddr (rdPtr),
    .rdData (rdData)
  );

  assign rxIf.OutData    = rdData;
  assign rxIf.OutValid   = outValid;
  assign rxIf.Count      = count;
  assign rxIf.AlmostFull = (count >= (AW+1)'(AFULL_LEVEL));
  assign rxIf.Overflow   = overflow;

endmodule
